cp0_count_bank: RTL and testbench

- Parametrised successor to the CP0 count unit: a bank of N_CH independent wide event counters, each with a compare register, match interrupt, sticky overflow flag and per-channel enable.
- Software sees a 32-bit register window addressed by channel and register select.
- 64-bit counters are read atomically through a low-read/high-shadow snapshot.
- Sits beside the CP0 register file; read_data feeds the mfc0 path and irq feeds the interrupt controller.

---
 rtl/cp0_count_bank.sv | 134 +++++++++++++
 tb/tb_cp0_count_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_count_bank.sv
// Bank of N_CH wide event counters with compare interrupts, sticky overflow and
// a 32-bit register window. Counter high halves are read through a snapshot shadow.
module cp0_count_bank #(
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   inc,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [1:0]        reg_sel,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic [N_CH-1:0]   irq
);

  localparam logic [1:0] REG_CNT_LO = 2'd0;
  localparam logic [1:0] REG_CNT_HI = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  logic [CNT_W-1:0]  cnt_r    [N_CH];
  logic [DATA_W-1:0] cmp_r    [N_CH];
  logic [DATA_W-1:0] shadow_r [N_CH];
  logic [N_CH-1:0]   en_r;
  logic [N_CH-1:0]   ie_r;
  logic [N_CH-1:0]   ovf_r;
  logic [N_CH-1:0]   pend_r;
  logic [DATA_W-1:0] read_data_r;
  logic              rd_valid_r;

  logic [N_CH-1:0]   sel_ch_s;
  logic [N_CH-1:0]   wr_ch_s;
  logic [N_CH-1:0]   cnt_wr_s;
  logic [N_CH-1:0]   inc_fire_s;
  logic [N_CH-1:0]   match_s;
  logic [N_CH-1:0]   wrap_s;
  logic [DATA_W-1:0] ch_word_s [N_CH];
  logic [DATA_W-1:0] rd_mux_s;

  // Per-channel decode of the register window and the increment/match/wrap conditions.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sel_ch_s[i]   = (ch_sel == CH_W'(i));
      wr_ch_s[i]    = wr_en && sel_ch_s[i];
      // A counter write takes priority over the event strobe on the same channel.
      cnt_wr_s[i]   = wr_ch_s[i] && ((reg_sel == REG_CNT_LO) || (reg_sel == REG_CNT_HI));
      inc_fire_s[i] = en_r[i] && inc[i] && !cnt_wr_s[i];
      match_s[i]    = inc_fire_s[i] && ((cnt_r[i][DATA_W-1:0] + DATA_W'(1)) == cmp_r[i]);
      wrap_s[i]     = inc_fire_s[i] && (&cnt_r[i]);
    end
  end

  // Read mux; unmatched channel selects contribute zero, so out-of-range reads return 0.
  always_comb begin
    rd_mux_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (reg_sel)
        REG_CNT_LO: ch_word_s[i] = cnt_r[i][DATA_W-1:0];
        REG_CNT_HI: ch_word_s[i] = shadow_r[i];
        REG_CMP:    ch_word_s[i] = cmp_r[i];
        REG_CTRL:   ch_word_s[i] = {{(DATA_W-3){1'b0}}, ovf_r[i], ie_r[i], en_r[i]};
        default:    ch_word_s[i] = '0;
      endcase
      rd_mux_s = rd_mux_s | (sel_ch_s[i] ? ch_word_s[i] : '0);
    end
  end

  // Channel state, shadow snapshot and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_r <= '0;
      rd_valid_r  <= 1'b0;
      en_r        <= '0;
      ie_r        <= '0;
      ovf_r       <= '0;
      pend_r      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i]    <= '0;
        cmp_r[i]    <= {DATA_W{1'b1}};
        shadow_r[i] <= '0;
      end
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        read_data_r <= rd_mux_s;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_wr_s[i]) begin
          if (reg_sel == REG_CNT_LO) begin
            cnt_r[i] <= {cnt_r[i][CNT_W-1:DATA_W], wr_data};
          end else begin
            cnt_r[i] <= {wr_data, cnt_r[i][DATA_W-1:0]};
          end
        end else if (inc_fire_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end

        // A fresh wrap outranks a simultaneous write-1-to-clear so no overflow is lost.
        if (wrap_s[i]) begin
          ovf_r[i] <= 1'b1;
        end else if (wr_ch_s[i] && (reg_sel == REG_CTRL) && wr_data[2]) begin
          ovf_r[i] <= 1'b0;
        end

        if (wr_ch_s[i] && (reg_sel == REG_CTRL)) begin
          en_r[i] <= wr_data[0];
          ie_r[i] <= wr_data[1];
        end

        if (wr_ch_s[i] && (reg_sel == REG_CMP)) begin
          cmp_r[i]  <= wr_data;
          pend_r[i] <= 1'b0;
        end else if (match_s[i]) begin
          pend_r[i] <= 1'b1;
        end

        if (rd_en && sel_ch_s[i] && (reg_sel == REG_CNT_LO)) begin
          shadow_r[i] <= cnt_r[i][CNT_W-1:DATA_W];
        end
      end
    end
  end

  assign read_data = read_data_r;
  assign rd_valid  = rd_valid_r;
  assign irq       = pend_r & ie_r;

endmodule

// File: tb/tb_cp0_count_bank.sv
// Directed scoreboard bench for cp0_count_bank: reads push expected words and
// a monitor pops and compares them whenever rd_valid is presented.
module tb_cp0_count_bank;

  localparam logic [1:0] LO = 2'd0;
  localparam logic [1:0] HI = 2'd1;
  localparam logic [1:0] CMP = 2'd2;
  localparam logic [1:0] CTRL = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  inc;
  logic [1:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] read_data;
  logic        rd_valid;
  logic [3:0]  irq;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  cp0_count_bank dut (
    .clk(clk), .rst(rst), .inc(inc), .ch_sel(ch_sel), .reg_sel(reg_sel),
    .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
    .read_data(read_data), .rd_valid(rd_valid), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding read, one cycle after issue.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.name, read_data, e.data);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] rs, input logic [31:0] d);
    wr_en = 1'b1; ch_sel = ch; reg_sel = rs; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push(input string name, input logic [31:0] d);
    exp_t e;
    e.data = d; e.cyc = cyc + 1; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic rd(input string name, input logic [1:0] ch, input logic [1:0] rs, input logic [31:0] d);
    rd_en = 1'b1; ch_sel = ch; reg_sel = rs;
    push(name, d);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m, input int n);
    inc = m;
    repeat (n) tick();
    inc = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inc = 4'd0; ch_sel = 2'd0; reg_sel = 2'd0;
    rd_en = 1'b0; wr_en = 1'b0; wr_data = 32'd0;
    tick(); tick();
    check("rst_read_data", read_data, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_irq", {28'd0, irq}, 32'd0);
    rst = 1'b0;
    tick();
    rd("rst_cmp1", 2'd1, CMP, 32'hFFFF_FFFF);
    rd("rst_ctrl1", 2'd1, CTRL, 32'd0);

    // ch0 basic counting
    wr(2'd0, CTRL, 32'd1);
    pulse(4'b0001, 5);
    rd("ch0_lo5", 2'd0, LO, 32'd5);
    rd("ch0_hi0", 2'd0, HI, 32'd0);
    tick();

    // ch1 atomic 64-bit read across a low-word carry
    wr(2'd1, LO, 32'hFFFF_FFFF);
    wr(2'd1, HI, 32'd0);
    wr(2'd1, CTRL, 32'd1);
    rd_en = 1'b1; ch_sel = 2'd1; reg_sel = LO; inc = 4'b0010;
    push("ch1_lo_carry", 32'hFFFF_FFFF);
    tick();
    rd_en = 1'b0; inc = 4'd0;
    rd("ch1_hi_shadow", 2'd1, HI, 32'd0);
    rd("ch1_lo_fresh", 2'd1, LO, 32'd0);
    rd("ch1_hi_fresh", 2'd1, HI, 32'd1);
    tick();
    check("hold_read_data", read_data, 32'd1);
    check("idle_rd_valid", {31'd0, rd_valid}, 32'd0);

    // ch2 compare interrupt, CMP-write clear, IE mask
    wr(2'd2, CMP, 32'd3);
    wr(2'd2, CTRL, 32'd3);
    pulse(4'b0100, 2);
    check("ch2_irq_before", {28'd0, irq}, 32'd0);
    pulse(4'b0100, 1);
    check("ch2_irq_match", {28'd0, irq}, 32'h4);
    wr(2'd2, CMP, 32'd10);
    check("ch2_irq_cmpclr", {28'd0, irq}, 32'd0);
    pulse(4'b0100, 7);
    check("ch2_irq_match10", {28'd0, irq}, 32'h4);
    wr(2'd2, CTRL, 32'd1);
    check("ch2_irq_masked", {28'd0, irq}, 32'd0);
    wr(2'd2, CTRL, 32'd3);
    check("ch2_irq_unmasked", {28'd0, irq}, 32'h4);
    wr(2'd2, CMP, 32'd12);
    pulse(4'b0100, 1);
    wr_en = 1'b1; ch_sel = 2'd2; reg_sel = CMP; wr_data = 32'h20; inc = 4'b0100;
    tick();
    wr_en = 1'b0; inc = 4'd0;
    check("ch2_clear_wins", {28'd0, irq}, 32'd0);
    rd("ch2_lo12", 2'd2, LO, 32'd12);

    // ch3 overflow: sticky, write-0 no effect, write-1 clears
    wr(2'd3, LO, 32'hFFFF_FFFF);
    wr(2'd3, HI, 32'hFFFF_FFFF);
    wr(2'd3, CTRL, 32'd1);
    pulse(4'b1000, 1);
    rd("ch3_ctrl_ovf", 2'd3, CTRL, 32'd5);
    rd("ch3_lo_wrap", 2'd3, LO, 32'd0);
    rd("ch3_hi_wrap", 2'd3, HI, 32'd0);
    wr(2'd3, CTRL, 32'd1);
    rd("ch3_ovf_sticky", 2'd3, CTRL, 32'd5);
    wr(2'd3, CTRL, 32'd5);
    rd("ch3_ovf_clear", 2'd3, CTRL, 32'd1);

    // read and write of the same register in one cycle returns the old value
    rd_en = 1'b1; wr_en = 1'b1; ch_sel = 2'd0; reg_sel = CMP; wr_data = 32'h55;
    push("ch0_cmp_old", 32'hFFFF_FFFF);
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    rd("ch0_cmp_new", 2'd0, CMP, 32'h55);

    // counter write wins over increment
    wr_en = 1'b1; ch_sel = 2'd0; reg_sel = LO; wr_data = 32'h100; inc = 4'b0001;
    tick();
    wr_en = 1'b0; inc = 4'd0;
    rd("ch0_wr_wins", 2'd0, LO, 32'h100);

    // reset mid-count with a read in flight
    wr(2'd2, CMP, 32'd13);
    inc = 4'b1111;
    tick();
    check("pre_rst_irq", {28'd0, irq}, 32'h4);
    rst = 1'b1; rd_en = 1'b1; ch_sel = 2'd0; reg_sel = LO;
    tick();
    check("rst_mid_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_mid_irq", {28'd0, irq}, 32'd0);
    check("rst_mid_read_data", read_data, 32'd0);
    rst = 1'b0; rd_en = 1'b0; inc = 4'd0;
    for (int c = 0; c < 4; c++) begin
      rd("post_rst_lo", 2'(c), LO, 32'd0);
      rd("post_rst_hi", 2'(c), HI, 32'd0);
    end
    rd("post_rst_ctrl2", 2'd2, CTRL, 32'd0);
    rd("post_rst_cmp2", 2'd2, CMP, 32'hFFFF_FFFF);
    tick(); tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
